// File: rtl/wb_b3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_b3_pkg: shared Wishbone B3 constants, FSM state type and clog2 helper.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package wb_b3_pkg;

  localparam logic [2:0] c_cti_classic = 3'b000;
  localparam logic [2:0] c_cti_const   = 3'b001;
  localparam logic [2:0] c_cti_incr    = 3'b010;
  localparam logic [2:0] c_cti_eob     = 3'b111;

  localparam logic [1:0] c_bte_linear  = 2'b00;
  localparam logic [1:0] c_bte_wrap4   = 2'b01;
  localparam logic [1:0] c_bte_wrap8   = 2'b10;
  localparam logic [1:0] c_bte_wrap16  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ACK   = 3'd2,
    ST_BURST = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_b3_burst_adr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_b3_burst_adr: next burst word index from the current index, CTI and BTE. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_b3_burst_adr
  import wb_b3_pkg::*;
#(
  parameter int IW    = 13,
  parameter int DEPTH = 5120
) (
  input  logic [IW-1:0] i_adr_q,
  input  logic [2:0]    i_cti,
  input  logic [1:0]    i_bte,
  output logic [IW-1:0] o_adr_next
);

  localparam logic [IW-1:0] c_last = IW'(DEPTH - 1);

  always_comb begin
    o_adr_next = i_adr_q;
    if (i_cti == c_cti_incr) begin
      case (i_bte)
        // Linear bursts fold back to word 0 past the last word of memory
        c_bte_linear: o_adr_next = (i_adr_q == c_last) ? '0 : i_adr_q + IW'(1);
        c_bte_wrap4:  o_adr_next = {i_adr_q[IW-1:2], i_adr_q[1:0] + 2'd1};
        c_bte_wrap8:  o_adr_next = {i_adr_q[IW-1:3], i_adr_q[2:0] + 3'd1};
        c_bte_wrap16: o_adr_next = {i_adr_q[IW-1:4], i_adr_q[3:0] + 4'd1};
        default:      o_adr_next = i_adr_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_wb_b3_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_wb_b3_param: parametrised Wishbone B3 slave RAM with bursts and errors. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ram_wb_b3_param
  import wb_b3_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int MEM_SIZE_BYTES = 32'h5000,
  parameter int MEM_ADR_WIDTH  = 15,
  parameter int WAIT_STATES    = 0,
  parameter     MEMORY_FILE    = ""
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_bte_i,
  input  logic [2:0]    wb_cti_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic [DW-1:0] wb_dat_o
);

  localparam int c_bytes = DW / 8;
  localparam int c_lsb   = clog2(c_bytes);
  localparam int c_iw    = MEM_ADR_WIDTH - c_lsb;
  localparam int c_depth = MEM_SIZE_BYTES / c_bytes;
  localparam logic [c_iw:0] c_depth_w   = (c_iw + 1)'(c_depth);
  localparam logic [3:0]    c_wait_last = 4'(WAIT_STATES - 1);

  logic [DW-1:0]   mem [0:c_depth-1];
  state_t          r_state;
  state_t          w_state_next;
  logic [c_iw-1:0] r_adr_q;
  logic [c_iw-1:0] w_adr_next;
  logic [3:0]      r_wait_cnt;
  logic [c_iw-1:0] w_index;
  logic            w_hi_set;
  logic            w_out_of_range;
  logic            w_match;
  logic            w_req;
  logic            w_unused;

  assign w_index  = wb_adr_i[MEM_ADR_WIDTH-1:c_lsb];
  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_unused = &{1'b0, wb_adr_i[AW-1:AW-4], wb_adr_i[c_lsb-1:0]};

  // The top address nibble is left to the interconnect decoder
  if (AW - 5 >= MEM_ADR_WIDTH) begin : g_hi_check
    assign w_hi_set = |wb_adr_i[AW-5:MEM_ADR_WIDTH];
  end else begin : g_no_hi_check
    assign w_hi_set = 1'b0;
  end

  assign w_out_of_range = w_hi_set | ({1'b0, w_index} >= c_depth_w);
  assign w_match        = ~w_out_of_range & (w_index == r_adr_q);

  wb_b3_burst_adr #(
    .IW    (c_iw),
    .DEPTH (c_depth)
  ) u_burst_adr (
    .i_adr_q    (r_adr_q),
    .i_cti      (wb_cti_i),
    .i_bte      (wb_bte_i),
    .o_adr_next (w_adr_next)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_out_of_range)
            w_state_next = ST_ERR;
          else if (wb_cti_i == c_cti_const || wb_cti_i == c_cti_incr)
            w_state_next = ST_BURST;
          else if (WAIT_STATES > 0)
            w_state_next = ST_WAIT;
          else
            w_state_next = ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!w_req)                        w_state_next = ST_IDLE;
        else if (r_wait_cnt == c_wait_last) w_state_next = ST_ACK;
      end
      ST_ACK: w_state_next = ST_IDLE;
      ST_BURST: begin
        if (!wb_cyc_i)
          w_state_next = ST_IDLE;
        else if (wb_stb_i) begin
          if (!w_match)
            w_state_next = ST_ERR;
          else if (wb_cti_i == c_cti_eob || wb_cti_i == c_cti_classic)
            w_state_next = ST_IDLE;
        end
      end
      ST_ERR:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    if (w_req) begin
      case (r_state)
        ST_ACK:   wb_ack_o = 1'b1;
        ST_BURST: wb_ack_o = w_match;
        ST_ERR:   wb_err_o = 1'b1;
        default:  ;
      endcase
    end
  end

  assign wb_rty_o = 1'b0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_adr_q    <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= '0;
          if (w_req && !w_out_of_range) r_adr_q <= w_index;
        end
        ST_WAIT:  r_wait_cnt <= r_wait_cnt + 4'd1;
        ST_BURST: if (wb_ack_o) r_adr_q <= w_adr_next;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_ack_o && wb_we_i) begin
      for (int b = 0; b < c_bytes; b++)
        if (wb_sel_i[b]) mem[r_adr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

  assign wb_dat_o = mem[r_adr_q];

endmodule
`default_nettype wire
